// File: rtl/mac_seq_4bits_pkg.sv
// Shared types and default sizing for the multiply-accumulate sequencer.
package mac_seq_4bits_pkg;

    // Default number of products summed per run.
    localparam int N_TERMS_DEF   = 4;

    // Default accumulator width: 8-bit products plus headroom for N_TERMS_DEF terms.
    localparam int ACC_WIDTH_DEF = 10;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_ACC_IDLE    = 3'd0,
        ST_ACC_LOAD    = 3'd1,
        ST_ACC_MULT    = 3'd2,
        ST_ACC_RELEASE = 3'd3,
        ST_ACC_DONE    = 3'd4
    } estado_acc_t;

    // Width of a counter that must hold the values 0..n.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mac_seq_4bits_controlador_acc.sv
// Sequencer FSM for the multiply-accumulate block.
//
// Handshake: a pair is consumed on a rising clk_i edge where valid_i and
// ready_o are both 1; ready_o depends on the current state only, so a
// producer may hold valid_i high for any length of time.
//
// All visible outputs are decoded from the state register. The strobes
// clr_o/load_o/acc_en_o are internal enables for the datapath registers.
import mac_seq_4bits_pkg::*;

module controlador_acc #(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int CNT_W   = count_width(N_TERMS_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    input  logic              mult_fim_i,
    input  logic [CNT_W-1:0]  count_i,
    output estado_acc_t       state_o,
    output logic              ready_o,
    output logic              mult_en_o,
    output logic              done_o,
    output logic              clr_o,
    output logic              load_o,
    output logic              acc_en_o
);

    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(N_TERMS);

    estado_acc_t state_q;
    estado_acc_t state_d;

    // State register, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_ACC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d  = state_q;
        clr_o    = 1'b0;
        load_o   = 1'b0;
        acc_en_o = 1'b0;
        case (state_q)
            ST_ACC_IDLE: begin
                if (start_i) begin
                    clr_o   = 1'b1;
                    state_d = ST_ACC_LOAD;
                end
            end
            ST_ACC_LOAD: begin
                if (valid_i) begin
                    load_o  = 1'b1;
                    state_d = ST_ACC_MULT;
                end
            end
            ST_ACC_MULT: begin
                // Only this transition captures a product, so a long fim level
                // is summed exactly once.
                if (mult_fim_i) begin
                    acc_en_o = 1'b1;
                    state_d  = ST_ACC_RELEASE;
                end
            end
            ST_ACC_RELEASE: begin
                // Wait for the multiplier to drop fim before launching again.
                if (!mult_fim_i) begin
                    state_d = (count_i == COUNT_LAST) ? ST_ACC_DONE : ST_ACC_LOAD;
                end
            end
            ST_ACC_DONE: begin
                if (start_i) begin
                    clr_o   = 1'b1;
                    state_d = ST_ACC_LOAD;
                end
            end
            default: begin
                state_d = ST_ACC_IDLE;
            end
        endcase
    end

    assign state_o   = state_q;
    assign ready_o   = (state_q == ST_ACC_LOAD);
    assign mult_en_o = (state_q == ST_ACC_MULT);
    assign done_o    = (state_q == ST_ACC_DONE);

endmodule

// File: rtl/mac_seq_4bits.sv
// Multiply-accumulate sequencer around the 4-bit shift-add multiplier.
// Feeds operand pairs to the multiplier one at a time and sums N_TERMS
// products into acc_o. The sum wraps modulo 2^ACC_WIDTH.
import mac_seq_4bits_pkg::*;

module mac_seq_4bits #(
    parameter int N_TERMS   = N_TERMS_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [3:0]                       a_i,
    input  logic [3:0]                       b_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic [3:0]                       mult_a_o,
    output logic [3:0]                       mult_b_o,
    output logic                             mult_en_o,
    input  logic [7:0]                       mult_y_i,
    input  logic                             mult_fim_i,
    output logic [ACC_WIDTH-1:0]             acc_o,
    output logic [$clog2(N_TERMS+1)-1:0]     count_o,
    output logic                             done_o
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    estado_acc_t state;
    logic        clr;
    logic        load;
    logic        acc_en;

    logic [3:0]           a_q,     a_d;
    logic [3:0]           b_q,     b_d;
    logic [ACC_WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0]     count_q, count_d;

    controlador_acc #(
        .N_TERMS (N_TERMS),
        .CNT_W   (CNT_W)
    ) u_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .mult_fim_i (mult_fim_i),
        .count_i    (count_q),
        .state_o    (state),
        .ready_o    (ready_o),
        .mult_en_o  (mult_en_o),
        .done_o     (done_o),
        .clr_o      (clr),
        .load_o     (load),
        .acc_en_o   (acc_en)
    );

    // Datapath next values: clear on start, capture on handshake, sum on product.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        count_d = count_q;
        if (clr) begin
            acc_d   = '0;
            count_d = '0;
        end
        if (load) begin
            a_d = a_i;
            b_d = b_i;
        end
        if (acc_en) begin
            acc_d   = acc_q + ACC_WIDTH'(mult_y_i);
            count_d = count_q + CNT_W'(1);
        end
    end

    // Datapath registers, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign mult_a_o = a_q;
    assign mult_b_o = b_q;
    assign acc_o    = acc_q;
    assign count_o  = count_q;

    // The state is observable through u_ctrl.state_o; nothing else here needs it.
    logic unused_state;
    assign unused_state = ^state;

endmodule
